// File: rtl/mac_acc_pipe_if.sv
// Sample/result bundle for mac_acc_pipe: valid-qualified operand pair in,
// accumulator value with its valid pulse and sticky overflow out.
interface mac_acc_pipe_if #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 20
);
    logic signed [IN_W-1:0]  a;
    logic signed [IN_W-1:0]  b;
    logic                    valid_in;
    logic                    clear_acc;
    logic signed [ACC_W-1:0] f;
    logic                    valid_out;
    logic                    overflow;

    modport master (
        output a, b, valid_in, clear_acc,
        input  f, valid_out, overflow
    );

    modport slave (
        input  a, b, valid_in, clear_acc,
        output f, valid_out, overflow
    );
endinterface

// File: rtl/mac_acc_pipe.sv
// Signed multiply-accumulate: f accumulates a*b over accepted samples, with
// optional product register stage, saturate/wrap mode and sticky overflow.
module mac_acc_pipe #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 20,
    parameter int PIPE  = 0,
    parameter int SAT   = 1
) (
    input logic         clk,
    input logic         reset,
    mac_acc_pipe_if.slave bus
);
    localparam int PROD_W = 2 * IN_W;

    if (ACC_W < 2 * IN_W) begin : g_bad_width
        $error("mac_acc_pipe: ACC_W (%0d) must be >= 2*IN_W (%0d)", ACC_W, 2 * IN_W);
    end

    logic signed [IN_W-1:0] a_r;
    logic signed [IN_W-1:0] b_r;
    logic                   clr_r;
    logic                   v_r;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its sources.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r   <= '0;
            b_r   <= '0;
            clr_r <= 1'b0;
            v_r   <= 1'b0;
        end else begin
            v_r <= bus.valid_in;
            if (bus.valid_in) begin
                a_r   <= bus.a;
                b_r   <= bus.b;
                clr_r <= bus.clear_acc;
            end
        end
    end

    logic signed [PROD_W-1:0] a_x;
    logic signed [PROD_W-1:0] b_x;
    logic signed [PROD_W-1:0] prod;

    assign a_x  = PROD_W'(a_r);
    assign b_x  = PROD_W'(b_r);
    assign prod = a_x * b_x;

    logic [PROD_W-1:0] acc_prod;
    logic              acc_v;
    logic              acc_clr;

    if (PIPE != 0) begin : g_pipe
        logic [PROD_W-1:0] p_r;
        logic              pv_r;
        logic              pc_r;

        always_ff @(posedge clk) begin
            if (reset) begin
                p_r  <= '0;
                pv_r <= 1'b0;
                pc_r <= 1'b0;
            end else begin
                pv_r <= v_r;
                pc_r <= clr_r;
                p_r  <= prod;
            end
        end

        assign acc_prod = p_r;
        assign acc_v    = pv_r;
        assign acc_clr  = pc_r;
    end else begin : g_nopipe
        assign acc_prod = prod;
        assign acc_v    = v_r;
        assign acc_clr  = clr_r;
    end

    logic [ACC_W-1:0] f_r;
    logic             ov_r;
    logic             vo_r;

    logic [ACC_W:0]   base;
    logic [ACC_W:0]   sum;
    logic             range_ovf;
    logic [ACC_W-1:0] f_next;

    // One guard bit above ACC_W: the sum is out of range exactly when the
    // guard bit disagrees with the accumulator sign bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        base      = acc_clr ? '0 : {f_r[ACC_W-1], f_r};
        sum       = base + {{(ACC_W + 1 - PROD_W){acc_prod[PROD_W-1]}}, acc_prod};
        range_ovf = sum[ACC_W] ^ sum[ACC_W-1];
        f_next    = sum[ACC_W-1:0];
        if (SAT != 0 && range_ovf) begin
            f_next = sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                : {1'b0, {(ACC_W - 1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_r  <= '0;
            ov_r <= 1'b0;
            vo_r <= 1'b0;
        end else begin
            vo_r <= acc_v;
            if (acc_v) begin
                f_r  <= f_next;
                ov_r <= (ov_r & ~acc_clr) | range_ovf;
            end
        end
    end

    assign bus.f         = f_r;
    assign bus.overflow  = ov_r;
    assign bus.valid_out = vo_r;
endmodule

// File: tb/tb_mac_acc_pipe.sv
// Self-checking bench for mac_acc_pipe: three configurations driven in
// lockstep, checked by constant vectors and a per-sample arithmetic model.
module tb_mac_acc_pipe;
    localparam int IN_W  = 8;
    localparam int ACC_W = 20;
    localparam int NCFG  = 3;
    localparam int HMAX  = 4096;
    localparam longint ACC_MAX = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W - 1));

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mac_acc_pipe_if #(.IN_W(IN_W), .ACC_W(ACC_W)) if0 ();
    mac_acc_pipe_if #(.IN_W(IN_W), .ACC_W(ACC_W)) if1 ();
    mac_acc_pipe_if #(.IN_W(IN_W), .ACC_W(ACC_W)) if2 ();

    mac_acc_pipe #(.IN_W(IN_W), .ACC_W(ACC_W), .PIPE(0), .SAT(1)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    mac_acc_pipe #(.IN_W(IN_W), .ACC_W(ACC_W), .PIPE(0), .SAT(0)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    mac_acc_pipe #(.IN_W(IN_W), .ACC_W(ACC_W), .PIPE(1), .SAT(1)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: each config consumes the sample accepted 1+pipe edges
    // earlier, unless a reset edge came after that sample was accepted.
    int     cfg_pipe [NCFG] = '{0, 0, 1};
    int     cfg_sat  [NCFG] = '{1, 0, 1};
    longint mf  [NCFG];
    bit     mov [NCFG];
    bit     mvo [NCFG];
    bit     hv  [HMAX];
    bit     hc  [HMAX];
    int     ha  [HMAX];
    int     hb  [HMAX];
    int     cyc = 0;
    int     last_rst = -1;

    task automatic model_edge(input bit r, input bit v, input bit c, input int av, input int bv);
        for (int k = 0; k < NCFG; k++) begin
            int     src;
            longint s;
            longint w;
            bit     o;
            src = cyc - 1 - cfg_pipe[k];
            mvo[k] = 1'b0;
            if (r) begin
                mf[k]  = 0;
                mov[k] = 1'b0;
            end else if (src >= 0 && src > last_rst && hv[src]) begin
                s = (hc[src] ? 64'sd0 : mf[k]) + longint'(ha[src]) * longint'(hb[src]);
                o = (s > ACC_MAX) || (s < ACC_MIN);
                mov[k] = (hc[src] ? 1'b0 : mov[k]) | o;
                if (cfg_sat[k] != 0) begin
                    mf[k] = (s > ACC_MAX) ? ACC_MAX : (s < ACC_MIN) ? ACC_MIN : s;
                end else begin
                    w = s & ((64'sd1 <<< ACC_W) - 1);
                    if (w > ACC_MAX) w = w - (64'sd1 <<< ACC_W);
                    mf[k] = w;
                end
                mvo[k] = 1'b1;
            end
        end
        if (r) last_rst = cyc;
        hv[cyc] = v & ~r;
        hc[cyc] = c;
        ha[cyc] = av;
        hb[cyc] = bv;
        cyc++;
    endtask

    task automatic compare_model();
        longint gf;
        bit     gv;
        bit     go;
        for (int k = 0; k < NCFG; k++) begin
            case (k)
                0:       begin gf = if0.f; gv = if0.valid_out; go = if0.overflow; end
                1:       begin gf = if1.f; gv = if1.valid_out; go = if1.overflow; end
                default: begin gf = if2.f; gv = if2.valid_out; go = if2.overflow; end
            endcase
            check($sformatf("model_f_cfg%0d_cyc%0d", k, cyc), gf, mf[k]);
            check($sformatf("model_vo_cfg%0d_cyc%0d", k, cyc), longint'(gv), longint'(mvo[k]));
            check($sformatf("model_ov_cfg%0d_cyc%0d", k, cyc), longint'(go), longint'(mov[k]));
        end
    endtask

    // Drive one edge's worth of inputs, advance the model, then compare #1 after.
    task automatic step(input bit r, input bit v, input bit c, input int av, input int bv);
        @(negedge clk);
        reset         = r;
        if0.valid_in  = v;  if1.valid_in  = v;  if2.valid_in  = v;
        if0.clear_acc = c;  if1.clear_acc = c;  if2.clear_acc = c;
        if0.a = IN_W'(av);  if1.a = IN_W'(av);  if2.a = IN_W'(av);
        if0.b = IN_W'(bv);  if1.b = IN_W'(bv);  if2.b = IN_W'(bv);
        @(posedge clk);
        model_edge(r, v, c, av, bv);
        #1;
        compare_model();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    typedef struct {
        bit  rst;
        bit  v;
        bit  clr;
        int  a;
        int  b;
        bit  exp_vo;
        int  exp_f;
        bit  exp_ov;
    } vec_t;

    vec_t tbl [9];

    initial begin
        bit stream_exp [7];

        if0.valid_in = 1'b0; if1.valid_in = 1'b0; if2.valid_in = 1'b0;
        if0.clear_acc = 1'b0; if1.clear_acc = 1'b0; if2.clear_acc = 1'b0;
        if0.a = '0; if1.a = '0; if2.a = '0;
        if0.b = '0; if1.b = '0; if2.b = '0;
        for (int k = 0; k < NCFG; k++) begin
            mf[k] = 0; mov[k] = 1'b0; mvo[k] = 1'b0;
        end

        // Reset, basic accumulate, then signed extremes (checked on PIPE=0 SAT=1).
        tbl[0] = '{1'b1, 1'b0, 1'b0,    0,    0, 1'b0,      0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0,   21,   21, 1'b0,      0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0,   36,   36, 1'b1,    441, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0,    0,    0, 1'b1,   1737, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0,    0,    0, 1'b0,   1737, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, -128,  127, 1'b0,   1737, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, -128, -128, 1'b1, -16256, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0,    0,    0, 1'b1,    128, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0,    0,    0, 1'b0,    128, 1'b0};

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].clr, tbl[i].a, tbl[i].b);
            check($sformatf("tbl%0d_f", i), if0.f, tbl[i].exp_f);
            check($sformatf("tbl%0d_vo", i), longint'(if0.valid_out), longint'(tbl[i].exp_vo));
            check($sformatf("tbl%0d_ov", i), longint'(if0.overflow), longint'(tbl[i].exp_ov));
        end

        // Saturation run: 33 samples of 127*127 starting a fresh sum.
        for (int i = 0; i < 33; i++) begin
            step(1'b0, 1'b1, (i == 0), 127, 127);
            if (i == 32) begin
                check("sat32_f", if0.f, 516128);
                check("sat32_ov", longint'(if0.overflow), 0);
            end
        end
        idle();
        check("sat33_f", if0.f, 524287);
        check("sat33_ov", longint'(if0.overflow), 1);
        check("wrap33_f", if1.f, -516319);
        check("wrap33_ov", longint'(if1.overflow), 1);
        step(1'b0, 1'b1, 1'b0, -128, 127);
        idle();
        check("sat_down_f", if0.f, 508031);
        check("sat_down_ov", longint'(if0.overflow), 1);

        // Clear with a valid sample restarts sum and overflow; without valid it is ignored.
        step(1'b0, 1'b1, 1'b1, 2, 3);
        idle();
        check("clear_f", if0.f, 6);
        check("clear_ov", longint'(if0.overflow), 0);
        step(1'b0, 1'b0, 1'b1, 5, 0);
        idle();
        check("noclear_f", if0.f, 6);
        check("noclear_vo", longint'(if0.valid_out), 0);

        // Two-cycle latency and back-to-back stream on the pipelined config.
        idle();
        idle();
        step(1'b0, 1'b1, 1'b1, 21, 21);
        idle();
        check("p1_e1_vo", longint'(if2.valid_out), 0);
        idle();
        check("p1_e2_vo", longint'(if2.valid_out), 1);
        check("p1_e2_f", if2.f, 441);
        stream_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            if (i < 4) step(1'b0, 1'b1, 1'b0, i + 1, 2);
            else       idle();
            check($sformatf("p1_stream_vo%0d", i), longint'(if2.valid_out), longint'(stream_exp[i]));
        end

        // Reset with samples in flight drops them.
        step(1'b0, 1'b1, 1'b1, 5, 5);
        step(1'b0, 1'b1, 1'b0, 6, 6);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        check("rst_f", if2.f, 0);
        check("rst_vo", longint'(if2.valid_out), 0);
        check("rst_ov", longint'(if2.overflow), 0);
        idle();
        check("rst_late1_vo", longint'(if2.valid_out), 0);
        idle();
        check("rst_late2_vo", longint'(if2.valid_out), 0);
        step(1'b0, 1'b1, 1'b0, 3, 3);
        idle();
        idle();
        check("post_rst_vo", longint'(if2.valid_out), 1);
        check("post_rst_f", if2.f, 9);

        // Randomized traffic; extreme same-sign or opposite-sign runs push into both limits.
        for (int i = 0; i < 2000; i++) begin
            bit r;
            bit v;
            bit c;
            int av;
            int bv;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 9) < 7) begin
                av = ($urandom_range(0, 1) != 0) ? 127 : -128;
                if (((i / 200) % 2) == 0) bv = av;
                else                      bv = (av == 127) ? -128 : 127;
            end else begin
                av = int'($urandom_range(0, 255)) - 128;
                bv = int'($urandom_range(0, 255)) - 128;
            end
            step(r, v, c, av, bv);
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
